// File: rtl/qsys_timer_mc.sv
// qsys_timer_mc
//   Multi-channel Avalon-MM interval timer. NUM_CH independent CNT_W-bit
//   down-counters share one programmable prescaler. Each channel has
//   one-shot/continuous operation, a snapshot register and a timeout flag;
//   the flags are combined into one level interrupt.
//
//   Address map (word address, slot = address[ADDR_W-1:2]):
//     slot c < NUM_CH : +0 STATUS {RUN,TO}   +1 CONTROL {STOP,START,CONT,ITO}
//                       +2 PERIOD            +3 SNAP
//     slot NUM_CH     : +0 PRESCALE          +1 PENDING (write-1-clears TO)
//                       +2 CH_INFO {NUM_CH,CNT_W}   +3 reads 0
//
// Ports
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   chipselect : slave select, qualifies writes only
//   address    : word address
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : registered read data, valid the cycle after address
//   irq        : level interrupt, OR of TO & ITO over all channels
module qsys_timer_mc #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 32,
  parameter int RESET_PER = 4999,
  parameter int PRE_W     = 16,
  parameter int ADDR_W    = $clog2(NUM_CH + 1) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int                SLOT_W      = ADDR_W - 2;
  localparam logic [SLOT_W-1:0] GLOBAL_SLOT = SLOT_W'(NUM_CH);
  localparam logic [CNT_W-1:0]  RST_CNT     = CNT_W'(RESET_PER);
  localparam logic [31:0]       CH_INFO     = {16'd0, 8'(NUM_CH), 8'(CNT_W)};

  logic              wr;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        regsel;

  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [CNT_W-1:0]  per  [NUM_CH];
  logic [CNT_W-1:0]  snap [NUM_CH];
  logic [3:0]        ctrl [NUM_CH];

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] ito;
  logic [NUM_CH-1:0] zero_p0;
  logic [NUM_CH-1:0] zero_p1;
  logic [NUM_CH-1:0] force_reload_p1;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_per;
  logic [NUM_CH-1:0] wr_snap;
  logic [NUM_CH-1:0] pend_clr;

  logic              wr_pre;
  logic              wr_pend;
  logic              tick;
  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  pre_cnt;
  logic [31:0]       rd_data_p0;

  assign wr       = chipselect & ~write_n;
  assign slot     = address[ADDR_W-1:2];
  assign regsel   = address[1:0];
  assign tick     = (pre_cnt == prescale);
  assign wr_pre   = wr && (slot == GLOBAL_SLOT) && (regsel == 2'd0);
  assign wr_pend  = wr && (slot == GLOBAL_SLOT) && (regsel == 2'd1);
  assign pend_clr = wr_pend ? writedata[NUM_CH-1:0] : '0;
  assign irq      = |(to & ito);

  // Per-channel write decode and status terms
  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_per    = '0;
    wr_snap   = '0;
    ito       = '0;
    zero_p0   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ito[c]     = ctrl[c][0];
      zero_p0[c] = (cnt[c] == '0);
      if (wr && (slot == SLOT_W'(c))) begin
        wr_status[c] = (regsel == 2'd0);
        wr_ctrl[c]   = (regsel == 2'd1);
        wr_per[c]    = (regsel == 2'd2);
        wr_snap[c]   = (regsel == 2'd3);
      end
    end
  end

  // Read mux, registered into readdata on every clock
  always_comb begin
    rd_data_p0 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slot == SLOT_W'(c)) begin
        case (regsel)
          2'd0:    rd_data_p0 = {30'd0, run[c], to[c]};
          2'd1:    rd_data_p0 = {28'd0, ctrl[c]};
          2'd2:    rd_data_p0 = 32'(per[c]);
          default: rd_data_p0 = 32'(snap[c]);
        endcase
      end
    end
    if (slot == GLOBAL_SLOT) begin
      case (regsel)
        2'd0:    rd_data_p0 = 32'(prescale);
        2'd1:    rd_data_p0 = 32'(to);
        2'd2:    rd_data_p0 = CH_INFO;
        default: rd_data_p0 = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata        <= '0;
      prescale        <= '0;
      pre_cnt         <= '0;
      run             <= '0;
      to              <= '0;
      force_reload_p1 <= '0;
      // A zero reset period would otherwise look like a fresh timeout edge.
      zero_p1         <= {NUM_CH{RESET_PER == 0}};
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]  <= RST_CNT;
        per[c]  <= RST_CNT;
        snap[c] <= '0;
        ctrl[c] <= '0;
      end
    end else begin
      // Stage p0 -> p1: read data, delayed reload request, previous zero flag
      readdata        <= rd_data_p0;
      force_reload_p1 <= wr_per;
      zero_p1         <= zero_p0;

      // A PRESCALE write restarts the count so the next tick is PRESCALE+1 clocks away.
      if (wr_pre) begin
        prescale <= writedata[PRE_W-1:0];
        pre_cnt  <= '0;
      end else if (tick) begin
        pre_cnt  <= '0;
      end else begin
        pre_cnt  <= pre_cnt + PRE_W'(1);
      end

      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_per[c])  per[c]  <= writedata[CNT_W-1:0];
        if (wr_ctrl[c]) ctrl[c] <= writedata[3:0];
        if (wr_snap[c]) snap[c] <= cnt[c];

        if (force_reload_p1[c])
          cnt[c] <= per[c];
        else if (tick && run[c])
          cnt[c] <= zero_p0[c] ? per[c] : cnt[c] - CNT_W'(1);

        // START beats STOP and the reload that follows a PERIOD write.
        if (wr_ctrl[c] && writedata[2])
          run[c] <= 1'b1;
        else if ((wr_ctrl[c] && writedata[3]) || force_reload_p1[c])
          run[c] <= 1'b0;
        else if (tick && run[c] && zero_p0[c] && !ctrl[c][1])
          run[c] <= 1'b0;

        // Clearing wins over a timeout edge in the same cycle.
        if (wr_status[c] || pend_clr[c])
          to[c] <= 1'b0;
        else if (zero_p0[c] && !zero_p1[c])
          to[c] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qsys_timer_mc.sv
// tb_qsys_timer_mc
//   Self-checking bench for qsys_timer_mc (NUM_CH=2, CNT_W=32). A reference
//   model tracks the timer from its register-level rules and is compared with
//   readdata/irq on every falling clock edge; directed sequences add literal
//   expectations, then randomized bus traffic follows.
module tb_qsys_timer_mc;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [3:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit done  = 0;

  qsys_timer_mc dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [31:0] m_cnt  [NCH];
  logic [31:0] m_per  [NCH];
  logic [31:0] m_snap [NCH];
  logic [3:0]  m_ctrl [NCH];
  bit          m_run  [NCH];
  bit          m_to   [NCH];
  bit          m_zprev[NCH];
  bit          m_frl  [NCH];
  int          m_pre;
  int          m_pcnt;
  logic [31:0] m_rd;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 4999; m_per[c] = 4999; m_snap[c] = 0; m_ctrl[c] = 0;
      m_run[c] = 0; m_to[c] = 0; m_zprev[c] = 0; m_frl[c] = 0;
    end
    m_pre = 0; m_pcnt = 0; m_rd = 0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    int slot = a >> 2;
    int r    = a & 3;
    logic [31:0] v = 0;
    if (slot < NCH) begin
      case (r)
        0: v = {30'd0, m_run[slot], m_to[slot]};
        1: v = {28'd0, m_ctrl[slot]};
        2: v = m_per[slot];
        default: v = m_snap[slot];
      endcase
    end else if (slot == NCH) begin
      case (r)
        0: v = m_pre;
        1: for (int c = 0; c < NCH; c++) v[c] = m_to[c];
        2: v = (NCH << 8) | 32;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  function automatic bit m_irq();
    bit v = 0;
    for (int c = 0; c < NCH; c++) if (m_to[c] && m_ctrl[c][0]) v = 1;
    return v;
  endfunction

  // One clock of timer behaviour, using the bus inputs present at the edge.
  task automatic m_step();
    int a, slot, r;
    bit wr, tick;
    a    = int'(address);
    slot = a >> 2;
    r    = a & 3;
    wr   = chipselect && !write_n;
    tick = (m_pcnt == m_pre);
    m_rd = m_read(a);
    for (int c = 0; c < NCH; c++) begin
      bit zero, hit, nrun, nto;
      logic [31:0] ncnt;
      zero = (m_cnt[c] == 0);
      hit  = wr && (slot == c);
      ncnt = m_cnt[c];
      if (tick && m_run[c]) ncnt = zero ? m_per[c] : m_cnt[c] - 1;
      if (m_frl[c]) ncnt = m_per[c];
      nrun = m_run[c];
      if (tick && m_run[c] && zero && !m_ctrl[c][1]) nrun = 0;
      if (m_frl[c] || (hit && r == 1 && writedata[3])) nrun = 0;
      if (hit && r == 1 && writedata[2]) nrun = 1;
      nto = m_to[c];
      if (zero && !m_zprev[c]) nto = 1;
      if ((hit && r == 0) || (wr && slot == NCH && r == 1 && writedata[c])) nto = 0;
      if (hit && r == 3) m_snap[c] = m_cnt[c];
      if (hit && r == 2) m_per[c] = writedata;
      if (hit && r == 1) m_ctrl[c] = writedata[3:0];
      m_frl[c]   = hit && (r == 2);
      m_zprev[c] = zero;
      m_cnt[c]   = ncnt;
      m_run[c]   = nrun;
      m_to[c]    = nto;
    end
    if (wr && slot == NCH && r == 0) begin
      m_pre  = int'(writedata & 32'h0000_FFFF);
      m_pcnt = 0;
    end else if (tick) begin
      m_pcnt = 0;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        n_vec++;
        if (readdata !== m_rd || irq !== m_irq()) begin
          n_err++;
          $display("FAIL model_cmp t=%0t readdata=%h irq=%b required readdata=%h irq=%b",
                   $time, readdata, irq, m_rd, m_irq());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%h) required=%0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 4'(a);
    writedata  = d;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    address = 4'(a);
    cycle();
    d = readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int k, t1;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Reset values
    bus_read(2, v);  check("reset_period", v, 4999);
    bus_read(0, v);  check("reset_status", v, 0);
    bus_read(10, v); check("ch_info", v, 32'h0000_0220);
    check("reset_irq", irq, 0);

    // One-shot, PERIOD=3, prescale 0
    bus_write(8, 0);
    bus_write(2, 3);
    bus_write(1, 5);
    k = 0;
    while (!irq && k < 20) begin cycle(); k++; end
    check("oneshot_latency", k, 4);
    bus_read(0, v); check("oneshot_status", v, 1);
    bus_write(0, 0);
    check("oneshot_irq_clear", irq, 0);

    // Continuous ch1 with prescale 4
    bus_write(6, 2);
    bus_write(8, 4);
    bus_write(5, 6);
    k = 0; v = 0;
    while (v[1] == 1'b0 && k < 60) begin bus_read(9, v); k++; end
    t1 = cyc;
    check("pending_set", v, 2);
    bus_write(9, 2);
    bus_read(9, v); check("pending_w1c", v, 0);
    k = 0; v = 0;
    while (v[1] == 1'b0 && k < 60) begin bus_read(9, v); k++; end
    check("cont_interval", cyc - t1, 15);
    bus_read(0, v); check("ch0_untouched", v, 0);

    // Clear colliding with a timeout edge; START with STOP
    bus_write(5, 8);
    bus_write(8, 0);
    bus_write(2, 3);
    bus_write(1, 5);
    repeat (3) cycle();
    bus_write(0, 0);
    check("collide_irq", irq, 0);
    bus_read(0, v); check("collide_status", v, 0);
    bus_write(1, 12);
    bus_read(0, v); check("start_stop_run", v, 2);

    // Snapshot of a running counter
    bus_write(2, 100);
    bus_write(1, 6);
    repeat (5) cycle();
    bus_write(3, 0);
    bus_read(3, v); check("snap_value", v, 95);
    bus_read(7, v); check("snap_other_ch", v, 0);

    // Asynchronous reset while both channels count
    bus_write(5, 7);
    repeat (6) cycle();
    check("pre_reset_irq", irq, 1);
    bus_read(6, v); check("pre_reset_period", v, 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 0);
    check("async_reset_irq", irq, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    bus_write(3, 0);
    bus_read(3, v); check("reset_counter", v, 4999);
    bus_read(6, v); check("reset_period_ch1", v, 4999);
    bus_read(8, v); check("reset_prescale", v, 0);
    bus_read(4, v); check("reset_status_ch1", v, 0);

    // Randomized bus traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int op;
      logic [3:0] a;
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      address    = a;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = $urandom;
      if (op < 3) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        if (a[3:2] < 2'd2 && a[1:0] == 2'd2) writedata = $urandom_range(0, 6);
        if (a == 4'd8) writedata = $urandom_range(0, 3);
        if (a[3:2] < 2'd2 && a[1:0] == 2'd1) writedata = $urandom_range(0, 15);
      end else if (op == 3) begin
        write_n = 1'b0;
      end else if (op == 4) begin
        chipselect = 1'b1;
      end
      cycle();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) cycle();

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
